// File: rtl/if_id_pipe_stage.sv
// if_id_pipe_stage: IF/ID register with valid/ready handshake, one-entry skid buffer,
// flush and saturating stall counter.
module if_id_pipe_stage #(
    parameter int                 PC_W      = 8,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}},
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CNT_W-1:0]   stall_cnt
);
    logic               skid_valid;
    logic [PC_W-1:0]    skid_pc;
    logic [INSTR_W-1:0] skid_instr;
    logic               accept;
    logic               take;
    logic               main_free;

    assign in_ready  = ~skid_valid;
    assign accept    = in_valid & in_ready;
    assign take      = out_valid & out_ready;
    assign main_free = ~out_valid | take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_instr  <= NOP_INSTR;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= NOP_INSTR;
        end else if (flush) begin
            out_valid  <= 1'b0;
            out_instr  <= NOP_INSTR;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            // skid always drains first to keep FIFO order
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_pc     <= skid_pc;
                out_instr  <= skid_instr;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_pc    <= in_pc;
                out_instr <= in_instr;
            end else begin
                out_valid <= 1'b0;
                out_instr <= NOP_INSTR;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_pc    <= in_pc;
            skid_instr <= in_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && !(&stall_cnt))
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_if_id_pipe_stage.sv
// tb_if_id_pipe_stage: directed checks of handshake, skid, flush, stall counter and async reset.
module tb_if_id_pipe_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pc;
    logic [31:0] out_instr;
    logic [3:0]  stall_cnt;
    int          total = 0;
    int          bad = 0;

    if_id_pipe_stage #(.PC_W(8), .INSTR_W(32), .NOP_INSTR(32'h0000_0000), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic [7:0] pc);
        in_valid = v;
        in_pc    = pc;
        in_instr = 32'hB000_0000 | {24'h0, pc};
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        present(1'b0, 8'h00);
        #2;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_pc", {24'b0, out_pc}, 32'd0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_stall", {28'b0, stall_cnt}, 32'd0);
        step(); step();
        rst_n = 1'b1;

        // 1: streaming
        in_valid = 1'b1; in_pc = 8'h10; in_instr = 32'hA000_0001;
        step();
        chk("s1_valid", {31'b0, out_valid}, 32'd1);
        chk("s1_pc0", {24'b0, out_pc}, 32'h10);
        chk("s1_instr0", out_instr, 32'hA000_0001);
        in_pc = 8'h14; in_instr = 32'hA000_0002;
        step();
        chk("s1_pc1", {24'b0, out_pc}, 32'h14);
        chk("s1_instr1", out_instr, 32'hA000_0002);
        chk("s1_ready", {31'b0, in_ready}, 32'd1);
        in_pc = 8'h18; in_instr = 32'hA000_0003;
        step();
        chk("s1_pc2", {24'b0, out_pc}, 32'h18);
        chk("s1_instr2", out_instr, 32'hA000_0003);
        in_valid = 1'b0;
        step();
        chk("s1_empty", {31'b0, out_valid}, 32'd0);
        chk("s1_nop", out_instr, 32'h0);
        chk("s1_pchold", {24'b0, out_pc}, 32'h18);

        // 2: back-pressure
        out_ready = 1'b0;
        present(1'b1, 8'h20); step();
        chk("s2_main", {24'b0, out_pc}, 32'h20);
        present(1'b1, 8'h24); step();
        chk("s2_notready", {31'b0, in_ready}, 32'd0);
        chk("s2_hold0", {24'b0, out_pc}, 32'h20);
        chk("s2_stall1", {28'b0, stall_cnt}, 32'd1);
        present(1'b1, 8'h28); step();
        chk("s2_hold1", {24'b0, out_pc}, 32'h20);
        chk("s2_stall2", {28'b0, stall_cnt}, 32'd2);
        out_ready = 1'b1; step();
        chk("s2_out24", {24'b0, out_pc}, 32'h24);
        chk("s2_instr24", out_instr, 32'hB000_0024);
        chk("s2_ready", {31'b0, in_ready}, 32'd1);
        step();
        chk("s2_out28", {24'b0, out_pc}, 32'h28);
        chk("s2_v28", {31'b0, out_valid}, 32'd1);
        present(1'b0, 8'h00); step();
        chk("s2_drained", {31'b0, out_valid}, 32'd0);

        // 3: flush with full skid
        out_ready = 1'b0;
        present(1'b1, 8'h30); step();
        present(1'b1, 8'h34); step();
        chk("s3_full", {31'b0, in_ready}, 32'd0);
        present(1'b1, 8'h38); flush = 1'b1; step();
        chk("s3_valid", {31'b0, out_valid}, 32'd0);
        chk("s3_nop", out_instr, 32'h0);
        chk("s3_ready", {31'b0, in_ready}, 32'd1);
        chk("s3_stall", {28'b0, stall_cnt}, 32'd4);
        flush = 1'b0; present(1'b0, 8'h00); out_ready = 1'b1; step();
        chk("s3_gone", {31'b0, out_valid}, 32'd0);

        // 6: take and accept together
        present(1'b1, 8'h3C); step();
        chk("s6_first", {24'b0, out_pc}, 32'h3C);
        present(1'b1, 8'h40); step();
        chk("s6_pc", {24'b0, out_pc}, 32'h40);
        chk("s6_ready", {31'b0, in_ready}, 32'd1);
        present(1'b0, 8'h00); step();

        // 4: stall saturation
        out_ready = 1'b0;
        present(1'b1, 8'h50); step();
        present(1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step();
        chk("s4_mid", {28'b0, stall_cnt}, 32'd9);
        for (int i = 0; i < 15; i++) step();
        chk("s4_sat", {28'b0, stall_cnt}, 32'd15);
        chk("s4_heldpc", {24'b0, out_pc}, 32'h50);
        flush = 1'b1; step();
        flush = 1'b0;
        chk("s4_flushkeep", {28'b0, stall_cnt}, 32'd15);
        chk("s4_flushvalid", {31'b0, out_valid}, 32'd0);

        // 5: async reset with both entries full
        present(1'b1, 8'h60); step();
        present(1'b1, 8'h64); step();
        chk("s5_full", {31'b0, in_ready}, 32'd0);
        present(1'b0, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        chk("s5_valid", {31'b0, out_valid}, 32'd0);
        chk("s5_pc", {24'b0, out_pc}, 32'd0);
        chk("s5_ready", {31'b0, in_ready}, 32'd1);
        chk("s5_stall", {28'b0, stall_cnt}, 32'd0);
        step();
        rst_n = 1'b1; out_ready = 1'b1;
        present(1'b1, 8'h70); step();
        chk("s5_restart", {24'b0, out_pc}, 32'h70);
        present(1'b0, 8'h00); step();
        chk("s5_nostale", {31'b0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
